// File: rtl/ssd_sched_pkg.sv
// Shared types and constants for the seven-segment display source scheduler.
package ssd_sched_pkg;

  localparam int unsigned NUM_SRC = 3;
  localparam int unsigned DATA_W  = 10;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2
  } state_e;

  localparam logic [SEL_W-1:0] SEL_NONE = 2'b11;

  // One-hot source mask for an index; SEL_NONE maps to no source.
  function automatic logic [NUM_SRC-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    case (sel)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ssd_rr_pick.sv
// Round-robin source picker: first valid index after sel_i (wrapping), never sel_i itself.
// With sel_i = SEL_NONE the search starts at index 0, giving the lowest valid source.
module ssd_rr_pick
  import ssd_sched_pkg::*;
(
  input  logic [SEL_W-1:0]   sel_i,
  input  logic [NUM_SRC-1:0] vld_i,
  output logic [SEL_W-1:0]   nxt_c_o,
  output logic               found_c_o
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    nxt_c_o   = SEL_NONE;
    found_c_o = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (sel_i == SEL_NONE) begin
        cand = SEL_W'(k);
      end else begin
        cand = SEL_W'((32'(sel_i) + k + 32'd1) % NUM_SRC);
      end
      if (!found_c_o && (cand != sel_i) && vld_i[cand]) begin
        nxt_c_o   = cand;
        found_c_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ssd_display_sched.sv
// Time-multiplexes one 4-digit SSD between three signed readings: round-robin
// selection with dwell, periodic refresh capture and a forced blank between sources.
module ssd_display_sched
  import ssd_sched_pkg::*;
#(
  parameter int unsigned DWELL_TICKS   = 2000,
  parameter int unsigned GAP_TICKS     = 100,
  parameter int unsigned REFRESH_TICKS = 250,
  parameter int unsigned CNT_W         = 16
) (
  input  logic               DCLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] SRC_VLD,
  input  logic [DATA_W-1:0]  SRC0_DATA,
  input  logic [DATA_W-1:0]  SRC1_DATA,
  input  logic [DATA_W-1:0]  SRC2_DATA,
  input  logic               NEXT,
  input  logic               HOLD,
  output logic [DATA_W-1:0]  DOUT,
  output logic               BLANK,
  output logic [SEL_W-1:0]   SEL,
  output logic [NUM_SRC-1:0] SRC_ACK
);

  localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(DWELL_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_TICKS - 1);

  state_e             state_q,   state_d;
  logic [SEL_W-1:0]   sel_q,     sel_d;
  logic [DATA_W-1:0]  dout_q,    dout_d;
  logic               blank_q,   blank_d;
  logic [NUM_SRC-1:0] ack_q,     ack_d;
  logic [CNT_W-1:0]   gap_q,     gap_d;
  logic [CNT_W-1:0]   dwell_q,   dwell_d;
  logic [CNT_W-1:0]   refresh_q, refresh_d;

  logic [SEL_W-1:0]   pick_c;
  logic               found_c;
  logic               cur_vld_c;
  logic               advance_c;
  logic [DATA_W-1:0]  cur_data_c;

  // In IDLE sel_q is SEL_NONE, so one picker serves both first pick and advance.
  ssd_rr_pick u_pick (
    .sel_i     (sel_q),
    .vld_i     (SRC_VLD),
    .nxt_c_o   (pick_c),
    .found_c_o (found_c)
  );

  always_comb begin
    cur_data_c = dout_q;
    case (sel_q)
      2'd0:    cur_data_c = SRC0_DATA;
      2'd1:    cur_data_c = SRC1_DATA;
      2'd2:    cur_data_c = SRC2_DATA;
      default: cur_data_c = dout_q;
    endcase
  end

  assign cur_vld_c = |(SRC_VLD & sel_onehot(sel_q));
  assign advance_c = (!HOLD && (dwell_q == DWELL_LAST)) || NEXT || !cur_vld_c;

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    dout_d    = dout_q;
    ack_d     = '0;
    gap_d     = gap_q;
    dwell_d   = dwell_q;
    refresh_d = refresh_q;

    case (state_q)
      IDLE: begin
        if (found_c) begin
          sel_d   = pick_c;
          gap_d   = '0;
          state_d = GAP;
        end
      end

      GAP: begin
        if (!cur_vld_c) begin
          gap_d = '0;
          if (found_c) begin
            sel_d = pick_c;
          end else begin
            sel_d   = SEL_NONE;
            state_d = IDLE;
          end
        end else if (gap_q == GAP_LAST) begin
          dout_d    = cur_data_c;
          ack_d     = sel_onehot(sel_q);
          dwell_d   = '0;
          refresh_d = '0;
          state_d   = SHOW;
        end else begin
          gap_d = gap_q + CNT_W'(1);
        end
      end

      SHOW: begin
        if (!HOLD) begin
          dwell_d = dwell_q + CNT_W'(1);
        end
        if (refresh_q == REFRESH_LAST) begin
          refresh_d = '0;
          dout_d    = cur_data_c;
          ack_d     = sel_onehot(sel_q);
        end else begin
          refresh_d = refresh_q + CNT_W'(1);
        end
        // Leaving SHOW drops any coincident refresh so DOUT/ACK never follow the outgoing source.
        if (advance_c) begin
          if (found_c) begin
            sel_d   = pick_c;
            gap_d   = '0;
            dout_d  = dout_q;
            ack_d   = '0;
            state_d = GAP;
          end else if (cur_vld_c) begin
            dwell_d = '0;
          end else begin
            sel_d   = SEL_NONE;
            dout_d  = dout_q;
            ack_d   = '0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        sel_d   = SEL_NONE;
        state_d = IDLE;
      end
    endcase

    blank_d = (state_d != SHOW);
  end

  always_ff @(posedge DCLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      sel_q     <= SEL_NONE;
      dout_q    <= '0;
      blank_q   <= 1'b1;
      ack_q     <= '0;
      gap_q     <= '0;
      dwell_q   <= '0;
      refresh_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      dout_q    <= dout_d;
      blank_q   <= blank_d;
      ack_q     <= ack_d;
      gap_q     <= gap_d;
      dwell_q   <= dwell_d;
      refresh_q <= refresh_d;
    end
  end

  assign DOUT    = dout_q;
  assign BLANK   = blank_q;
  assign SEL     = sel_q;
  assign SRC_ACK = ack_q;

endmodule

// File: tb/tb_ssd_display_sched.sv
// Scoreboard bench for ssd_display_sched: expected captures are queued as stimulus
// is applied and matched against every SRC_ACK pulse; display state is spot-checked.
module tb_ssd_display_sched;

  typedef struct packed {
    logic [1:0] sel;
    logic [9:0] data;
  } cap_t;

  logic       DCLK = 1'b0;
  logic       RST;
  logic [2:0] SRC_VLD;
  logic [9:0] SRC0_DATA, SRC1_DATA, SRC2_DATA;
  logic       NEXT, HOLD;
  logic [9:0] DOUT;
  logic       BLANK;
  logic [1:0] SEL;
  logic [2:0] SRC_ACK;

  int   err_cnt = 0;
  int   chk_cnt = 0;
  cap_t exp_q[$];
  cap_t mon_e;

  ssd_display_sched #(
    .DWELL_TICKS   (8),
    .GAP_TICKS     (2),
    .REFRESH_TICKS (4),
    .CNT_W         (16)
  ) dut (
    .DCLK      (DCLK),
    .RST       (RST),
    .SRC_VLD   (SRC_VLD),
    .SRC0_DATA (SRC0_DATA),
    .SRC1_DATA (SRC1_DATA),
    .SRC2_DATA (SRC2_DATA),
    .NEXT      (NEXT),
    .HOLD      (HOLD),
    .DOUT      (DOUT),
    .BLANK     (BLANK),
    .SEL       (SEL),
    .SRC_ACK   (SRC_ACK)
  );

  always #5 DCLK = ~DCLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge DCLK);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] s, input logic [9:0] d);
    cap_t c;
    c.sel  = s;
    c.data = d;
    exp_q.push_back(c);
  endtask

  task automatic check_view(input string tag, input logic [1:0] s, input logic b);
    check({tag, "_sel"}, 32'(SEL), 32'(s));
    check({tag, "_blank"}, 32'(BLANK), 32'(b));
  endtask

  // Every capture pulse must match the oldest expected capture.
  always @(negedge DCLK) begin
    if (SRC_ACK != 3'b000) begin
      if (exp_q.size() == 0) begin
        check("ack_unexpected", 32'(SRC_ACK), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_onehot", 32'(SRC_ACK), 32'(3'b001 << mon_e.sel));
        check("ack_sel", 32'(SEL), 32'(mon_e.sel));
        check("ack_dout", 32'(DOUT), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RST = 1'b0; SRC_VLD = 3'b000; NEXT = 1'b0; HOLD = 1'b0;
    SRC0_DATA = '0; SRC1_DATA = '0; SRC2_DATA = '0;
    #1 RST = 1'b1;
    #1;
    check_view("reset", 2'b11, 1'b1);
    check("reset_dout", 32'(DOUT), 32'h000);
    check("reset_ack", 32'(SRC_ACK), 32'd0);

    // First selection: lowest valid source after a two-cycle gap.
    SRC0_DATA = 10'h20F; SRC1_DATA = 10'h0C3; SRC2_DATA = 10'h1A5;
    SRC_VLD = 3'b101;
    #20 RST = 1'b0;
    push_exp(2'd0, 10'h20F);
    tick(1); check_view("t1_gap0", 2'd0, 1'b1);
    tick(1); check_view("t1_gap1", 2'd0, 1'b1);
    tick(1); check_view("t1_show", 2'd0, 1'b0);
    check("t1_dout", 32'(DOUT), 32'h20F);

    // Refresh every 4, auto-advance after 8, exactly 2 blank cycles.
    push_exp(2'd0, 10'h20F);
    push_exp(2'd2, 10'h1A5);
    tick(7); check_view("t2_predwell", 2'd0, 1'b0);
    tick(1); check_view("t2_gap0", 2'd2, 1'b1);
    check("t2_gap_dout", 32'(DOUT), 32'h20F);
    tick(1); check_view("t2_gap1", 2'd2, 1'b1);
    tick(1); check_view("t2_show", 2'd2, 1'b0);
    check("t2_dout", 32'(DOUT), 32'h1A5);
    push_exp(2'd2, 10'h1A5);
    push_exp(2'd0, 10'h20F);
    tick(8); check_view("t2_wrap_gap", 2'd0, 1'b1);
    tick(2); check_view("t2_wrap_show", 2'd0, 1'b0);

    // HOLD freezes dwell, refresh picks up new data; NEXT overrides HOLD.
    HOLD = 1'b1; SRC0_DATA = 10'h0F3;
    repeat (5) push_exp(2'd0, 10'h0F3);
    tick(20); check_view("t3_held", 2'd0, 1'b0);
    check("t3_dout", 32'(DOUT), 32'h0F3);
    push_exp(2'd2, 10'h1A5);
    NEXT = 1'b1;
    tick(1); NEXT = 1'b0; HOLD = 1'b0;
    check_view("t3_next", 2'd2, 1'b1);
    tick(2); check_view("t3_show", 2'd2, 1'b0);

    // Current source drops -> next valid; then everything drops -> IDLE.
    push_exp(2'd0, 10'h0F3);
    SRC_VLD = 3'b001;
    tick(1); check_view("t4_drop", 2'd0, 1'b1);
    check("t4_drop_dout", 32'(DOUT), 32'h1A5);
    tick(2); check_view("t4_show", 2'd0, 1'b0);
    SRC_VLD = 3'b000;
    tick(1); check_view("t4_idle", 2'b11, 1'b1);
    check("t4_idle_dout", 32'(DOUT), 32'h0F3);
    tick(2); check_view("t4_idle_stay", 2'b11, 1'b1);

    // Single source: dwell expiry keeps showing with no gap and no extra capture.
    SRC_VLD = 3'b010;
    repeat (3) push_exp(2'd1, 10'h0C3);
    tick(3); check_view("t5_show", 2'd1, 1'b0);
    check("t5_dout", 32'(DOUT), 32'h0C3);
    tick(8); check_view("t5_expiry", 2'd1, 1'b0);
    tick(1); check_view("t5_after", 2'd1, 1'b0);

    // NEXT coincident with dwell expiry: one advance only.
    SRC_VLD = 3'b011;
    push_exp(2'd1, 10'h0C3);
    tick(6);
    NEXT = 1'b1;
    tick(1); NEXT = 1'b0;
    check_view("t5_coinc", 2'd0, 1'b1);
    tick(1); check_view("t5_coinc_gap1", 2'd0, 1'b1);

    // Asynchronous reset in the middle of the gap.
    #2 RST = 1'b1;
    #1;
    check_view("t6_rst", 2'b11, 1'b1);
    check("t6_rst_dout", 32'(DOUT), 32'h000);
    check("t6_rst_ack", 32'(SRC_ACK), 32'd0);
    check("t6_rst_queue", 32'(exp_q.size()), 32'd0);
    #13;
    push_exp(2'd0, 10'h0F3);
    RST = 1'b0;
    tick(1); check_view("t6_restart_gap", 2'd0, 1'b1);
    tick(2); check_view("t6_restart_show", 2'd0, 1'b0);
    check("t6_dout", 32'(DOUT), 32'h0F3);

    // Target drops during the gap: reselect and restart the gap count.
    push_exp(2'd0, 10'h0F3);
    NEXT = 1'b1;
    tick(1); NEXT = 1'b0; SRC_VLD = 3'b001;
    check_view("t7_gap", 2'd1, 1'b1);
    tick(1); check_view("t7_resel", 2'd0, 1'b1);
    tick(1); check_view("t7_gap1", 2'd0, 1'b1);
    tick(1); check_view("t7_show", 2'd0, 1'b0);
    check("t7_dout", 32'(DOUT), 32'h0F3);

    tick(2);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ssd_display_sched.md
Name: ssd_display_sched

Overview:
- Time-multiplexes one 4-digit seven-segment display between three 10-bit signed readings, e.g. accelerometer X/Y/Z or gyro axes.
- Picks the active source round-robin, holds it for a dwell period and refreshes the shown value at a fixed rate.
- Blanks the display briefly on every source change.
- Sits between the sensor datapaths and the SSD controller: DOUT feeds the controller's 10-bit DIN, and BLANK forces the controller's anodes off.

Parameters:
DWELL_TICKS, 2000, DCLK cycles a source stays shown before auto-advance (2 s at 1 kHz); must be >=1
GAP_TICKS, 100, DCLK cycles of forced blank between sources; must be >=1
REFRESH_TICKS, 250, DCLK cycles between re-captures of the shown source's data; must be >=1
CNT_W, 16, width of the internal tick counters; every *_TICKS parameter must be < 2**CNT_W

Ports:
DCLK  in  1  display tick clock (1 kHz)
RST  in  1  reset, asynchronous, active-high
SRC_VLD  in  3  per-source valid level; bit i means source i has data to show
SRC0_DATA  in  10  source 0 reading; bit 9 = sign (minus), bits 8:0 = magnitude
SRC1_DATA  in  10  source 1 reading, same format
SRC2_DATA  in  10  source 2 reading, same format
NEXT  in  1  single-DCLK pulse, already debounced: manual advance
HOLD  in  1  level: freezes the dwell counter (refresh continues)
DOUT  out  10  captured reading for the SSD controller
BLANK  out  1  1 = display must be dark
SEL  out  2  index of the shown source; 2'b11 = none
SRC_ACK  out  3  one-hot, 1-cycle pulse when source i's data is captured

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State IDLE.
  - SEL=2'b11, DOUT=10'h000, BLANK=1, SRC_ACK=3'b000.
  - Dwell, gap and refresh counters = 0.
- All outputs are registered; each output changes on the DCLK edge after its triggering condition.
- States: IDLE, GAP, SHOW.
- IDLE:
  - BLANK=1, SEL=3.
  - If SRC_VLD!=0: SEL <= lowest-index valid source, gap counter cleared, go to GAP.
- GAP:
  - BLANK=1. Gap counter counts 0..GAP_TICKS-1.
  - On the terminal count: DOUT <= selected SRCn_DATA, SRC_ACK[SEL] pulses, dwell and refresh counters cleared, go to SHOW.
  - If SRC_VLD[SEL] falls during GAP: pick the next valid source (or go to IDLE if none) and restart the gap counter.
  - NEXT and HOLD are ignored in GAP.
- SHOW:
  - BLANK=0.
  - Refresh counter counts 0..REFRESH_TICKS-1. At the terminal count: DOUT <= SRCn_DATA[SEL], SRC_ACK[SEL] pulses, counter wraps to 0.
  - Dwell counter increments each cycle while HOLD=0.
  - Advance event = dwell at DWELL_TICKS-1 (with HOLD=0), or NEXT=1 (NEXT acts even when HOLD=1), or SRC_VLD[SEL]=0.
  - Simultaneous triggers produce exactly one advance.
- Advance, round-robin search starting at SEL+1 and wrapping 2->0:
  - First valid index different from SEL found: SEL <= it, go to GAP.
  - Only the current source still valid: stay in SHOW, clear dwell. No gap, no extra capture.
  - No source valid: go to IDLE (BLANK=1 next cycle, SEL=3, DOUT keeps its last value).
- DOUT never changes while BLANK=0 except on a refresh capture.
- SRC_ACK is never multi-hot and never pulses in IDLE.

Decomposition:
- Package ssd_sched_pkg:
  - state encoding: IDLE=2'd0, GAP=2'd1, SHOW=2'd2
  - SEL_NONE=2'b11
  - NUM_SRC=3
  - DATA_W=10
- Sub-module ssd_rr_pick: combinational round-robin picker.
  - Inputs: current SEL and SRC_VLD.
  - Outputs: next index and found flag.
  - Used by both IDLE and advance paths; with SEL_NONE as input it returns the lowest valid index.

Test Plan (DWELL_TICKS=8, GAP_TICKS=2, REFRESH_TICKS=4):
1. Reset, then SRC_VLD=3'b101, SRC0_DATA=10'h20F -> SEL=0 after IDLE plus 2 GAP cycles; BLANK falls; DOUT=10'h20F; SRC_ACK=3'b001 pulses once.
2. Hold steady in SHOW with SRC0 -> SRC_ACK[0] pulses every 4 cycles; after 8 cycles SEL=2, BLANK high for exactly 2 cycles, then DOUT=SRC2_DATA.
3. HOLD=1 for 20 cycles on SEL=0 -> no advance and refresh pulses continue; pulse NEXT -> SEL moves to 2 via GAP.
4. Drop SRC_VLD[2] while SEL=2 in SHOW -> next cycle SEL=0 and state GAP; with SRC_VLD=0 instead -> IDLE, BLANK=1, SEL=3, DOUT unchanged.
5. Only SRC1 valid -> dwell expiry keeps SEL=1 with BLANK staying 0 and no extra ACK; NEXT coincident with dwell expiry on a two-source setup -> a single advance.
6. Assert RST mid-GAP, asynchronously between edges -> all outputs return to reset values immediately; after release, the sequence restarts from IDLE.
